uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver for the FPGA-side serial command path into the SDRAM controller. Replaces the fixed 8N1 receiver with configurable bit period, data width, parity, stop-bit count, 3-sample majority voting, false-start rejection, parity/framing error flags and a valid/ready output with overrun detection. Sits between the `rs232_rx` pin and the command decoder, which drains bytes with `rx_ready`.

## Interface
- `CLK_DIV`, 5208: sclk cycles per bit; legal range ≥ 8 (simulation uses 16).
- `DATA_BITS`, 8: data bits per frame, 5..8, LSB first.
- `PARITY`, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits, 1 or 2.

- `sclk` in 1: system clock.
- `s_rst` in 1: asynchronous reset, active-high.
- `rs232_rx` in 1: serial line, asynchronous, idle high.
- `rx_data` out DATA_BITS: received data word, valid while `rx_valid`.
- `rx_valid` out 1: holding register full.
- `rx_ready` in 1: consumer accepts the word when `rx_valid && rx_ready`.
- `parity_err` out 1: parity mismatch for the held word; qualified by `rx_valid`. Always 0 when PARITY = 0.
- `frame_err` out 1: any stop bit sampled 0 for the held word; qualified by `rx_valid`.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped.
- `rx_busy` out 1: FSM is not in IDLE.

## Operation
- **Synchroniser**:
  - Three flops, all reset to 1. Edge detect is `~s2 & s3`.
  - The sampling value is `s2`.
- **Timing constants**:
  - `MID = CLK_DIV/2 - 1` (integer division).
  - Bit index k: start bit = 0, data bits = 1..DATA_BITS, then parity (if enabled), then stop bit(s).
  - `K_LAST = DATA_BITS + (PARITY != 0) + STOP_BITS`.
- **Counters**:
  - `baud_cnt` counts 0..CLK_DIV-1 and wraps, active outside IDLE only.
  - `bit_idx` increments on each wrap.
- **Majority vote**:
  - `s2` is sampled at `baud_cnt` = MID-1, MID and MID+1.
  - The bit value is the majority of the 3 samples and is decided at MID+1.
- **FSM states**: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on edge detect; `baud_cnt` is cleared to 0.
  - START: if the vote is 1 (false start), return to IDLE with no output. Otherwise continue to DATA at the next wrap.
  - DATA: shift voted bits in LSB-first. Go to PARITY or STOP after DATA_BITS bits.
  - PARITY: check the XOR of data and the parity bit against the mode (even: XOR = 0; odd: XOR = 1).
  - STOP: any stop vote of 0 sets the frame error. After the vote of the final stop bit, go to IDLE immediately at MID+1. Do not wait for the end of the bit, so a back-to-back start edge in the second half of the stop bit is caught.
- **Completion** (final stop decision):
  - If the holding register is empty, or being accepted in the same cycle: load `rx_data`, `parity_err` and `frame_err`, and set `rx_valid`.
  - Otherwise: drop the new frame, keep the old word and flags, and pulse `overrun`.
- **Accept**: `rx_valid && rx_ready` with no completion clears `rx_valid` next cycle. `rx_data` and the flags hold their last values.
- **Frame errors**: frames with `frame_err` are still delivered. A break (line held low) yields one frame with data 0 and `frame_err`=1. No further frames arrive until the line returns high and falls again.

## Timing
- **Reset values**:
  - `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0.
  - FSM in IDLE, synchroniser flops at 1.
  - Reset mid-frame aborts the frame and asserts no output after release.
- **Latency**: t0 is the first sclk edge that samples `rs232_rx` low.
  - Edge detect at t0+3; START with `baud_cnt`=0 at t0+4.
  - `rx_valid` is first high at t0 + 4 + K_LAST·CLK_DIV + MID + 2.
- `overrun` is high for exactly the one cycle after the dropping completion.
- `rx_busy` is high from t0+4 until the cycle after the final stop decision.
- Simultaneous accept and completion: `rx_valid` stays 1 and the new word is visible the next cycle, with no overrun.

## Structure
- Shared include `uart_defs.vh` holds:
  - `PAR_NONE`/`PAR_EVEN`/`PAR_ODD` encodings.
  - FSM state localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
  - The `MID` formula.
  - The future `uart_tx_cfg` uses the same file.
- One sub-module `uart_rx_sync`: the 3-flop synchroniser plus edge detect. Outputs are `rx_s` and `rx_neg`.
- The FSM, counters, majority voter and holding register live in the top level.

## Test plan
Directed cases use CLK_DIV=16.

- **8N1, 0xA5**: `rx_valid` rises at t0+157 with `rx_data`=0xA5 and both error flags 0. A one-cycle `rx_ready` then clears it.
- **7E1** (DATA_BITS=7, PARITY=1): 0x35 with correct parity bit 0 → `parity_err`=0. The same word with parity bit 1 → `parity_err`=1, `rx_data`=0x35.
- **Glitch and noise**: a 4-cycle low glitch is rejected as a false start, with no `rx_valid` and `rx_busy` back to 0. A single-cycle inverted pulse at MID inside a data bit is voted out and the data is correct.
- **Framing and break (8N2)**: second stop bit driven 0 → `frame_err`=1. Line held low for 3 frames → exactly one frame with 0x00 and `frame_err`=1.
- **Back-to-back and overrun**: 0x11, 0x22, 0x33 sent back-to-back with `rx_ready`=0 → 0x11 held and two `overrun` pulses. With `rx_ready` tied 1 → three words, no overrun.
- **Reset mid-frame**: assert `s_rst` during data bit 4 → all outputs 0 immediately. A subsequent clean 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg_pkg.sv
// rtl/uart_rx_cfg_pkg.sv - shared UART encodings, FSM states and timing helpers
package uart_rx_cfg_pkg;

    // Parity mode encodings (shared with the transmitter side)
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Baud counter value treated as the middle of a bit
    function automatic int uart_mid(input int clk_div);
        return clk_div / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_sync.sv
// rtl/uart_rx_cfg_sync.sv - three-flop line synchroniser with falling-edge detect
module uart_rx_sync (
    input  logic sclk,
    input  logic s_rst,
    input  logic rs232_rx,
    output logic rx_s,
    output logic rx_neg
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Shift the asynchronous line through three flops; idle level is high
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= rs232_rx;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rx_s   = s2_q;
    assign rx_neg = ~s2_q & s3_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with voting, error flags and holding register
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int CLK_DIV   = 5208,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sclk,
    input  logic                 s_rst,
    input  logic                 rs232_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int CW     = $clog2(CLK_DIV);
    localparam int MID    = uart_mid(CLK_DIV);
    localparam int K_LAST = DATA_BITS + ((PARITY != PAR_NONE) ? 1 : 0) + STOP_BITS;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] MID_M1   = CW'(MID - 1);
    localparam logic [CW-1:0] MID_C    = CW'(MID);
    localparam logic [CW-1:0] MID_P1   = CW'(MID + 1);
    localparam logic [3:0]    IDX_DLST = 4'(DATA_BITS);
    localparam logic [3:0]    IDX_LAST = 4'(K_LAST);

    logic                 rx_s;
    logic                 rx_neg;
    logic                 rx_neg_q;
    logic                 vote;

    rx_state_e            state_q;
    logic [CW-1:0]        baud_cnt_q;
    logic [3:0]           bit_idx_q;
    logic [1:0]           samp_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_acc_q;
    logic                 ferr_acc_q;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 rx_busy_q;

    uart_rx_sync u_sync (
        .sclk     (sclk),
        .s_rst    (s_rst),
        .rs232_rx (rs232_rx),
        .rx_s     (rx_s),
        .rx_neg   (rx_neg)
    );

    // One extra stage on the edge detect so START opens with baud_cnt=0 four edges after the line is first seen low
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            rx_neg_q <= 1'b0;
        end else begin
            rx_neg_q <= rx_neg;
        end
    end

    // Two stored samples (MID-1, MID) plus the live sample at MID+1
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    // Frame FSM, baud/bit counters, voter sampling and the output holding register
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q      <= ST_IDLE;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            samp_q       <= 2'b11;
            shift_q      <= '0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_neg_q) begin
                        state_q    <= ST_START;
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        perr_acc_q <= 1'b0;
                        ferr_acc_q <= 1'b0;
                        rx_busy_q  <= 1'b1;
                    end
                end
                default: begin
                    if (baud_cnt_q == CNT_LAST) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= bit_idx_q + 4'd1;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end

                    if (baud_cnt_q == MID_M1) begin
                        samp_q[0] <= rx_s;
                    end
                    if (baud_cnt_q == MID_C) begin
                        samp_q[1] <= rx_s;
                    end

                    if (baud_cnt_q == MID_P1) begin
                        case (state_q)
                            ST_START: begin
                                if (vote) begin
                                    state_q   <= ST_IDLE;
                                    rx_busy_q <= 1'b0;
                                end
                            end
                            ST_DATA: begin
                                shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                            end
                            ST_PARITY: begin
                                perr_acc_q <= ((^shift_q) ^ vote) != (PARITY == PAR_ODD);
                            end
                            ST_STOP: begin
                                if (!vote) begin
                                    ferr_acc_q <= 1'b1;
                                end
                                // Leave at mid-bit so a start edge in the back half of the stop bit is caught
                                if (bit_idx_q == IDX_LAST) begin
                                    state_q   <= ST_IDLE;
                                    rx_busy_q <= 1'b0;
                                    if (!rx_valid_q || rx_ready) begin
                                        rx_valid_q   <= 1'b1;
                                        rx_data_q    <= shift_q;
                                        parity_err_q <= perr_acc_q;
                                        frame_err_q  <= ferr_acc_q | ~vote;
                                    end else begin
                                        overrun_q <= 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end

                    if (baud_cnt_q == CNT_LAST) begin
                        case (state_q)
                            ST_START:  state_q <= ST_DATA;
                            ST_DATA: begin
                                if (bit_idx_q == IDX_DLST) begin
                                    state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                                end
                            end
                            ST_PARITY: state_q <= ST_STOP;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg (8N1, 7E1, 8N2 instances)
module tb_uart_rx_cfg;

    localparam int CD = 16;

    logic clk;
    logic rst;
    logic a_rx, b_rx, c_rx;
    logic a_rdy, b_rdy, c_rdy;

    logic [7:0] a_data;
    logic [6:0] b_data;
    logic [7:0] c_data;
    logic a_valid, a_perr, a_ferr, a_ov, a_busy;
    logic b_valid, b_perr, b_ferr, b_ov, b_busy;
    logic c_valid, c_perr, c_ferr, c_ov, c_busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] a_q[$];
    logic [9:0] b_q[$];
    logic [9:0] c_q[$];
    int a_ovn = 0;
    int b_ovn = 0;
    int c_ovn = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .sclk(clk), .s_rst(rst), .rs232_rx(a_rx), .rx_data(a_data), .rx_valid(a_valid),
        .rx_ready(a_rdy), .parity_err(a_perr), .frame_err(a_ferr), .overrun(a_ov), .rx_busy(a_busy)
    );

    uart_rx_cfg #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_b (
        .sclk(clk), .s_rst(rst), .rs232_rx(b_rx), .rx_data(b_data), .rx_valid(b_valid),
        .rx_ready(b_rdy), .parity_err(b_perr), .frame_err(b_ferr), .overrun(b_ov), .rx_busy(b_busy)
    );

    uart_rx_cfg #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
        .sclk(clk), .s_rst(rst), .rs232_rx(c_rx), .rx_data(c_data), .rx_valid(c_valid),
        .rx_ready(c_rdy), .parity_err(c_perr), .frame_err(c_ferr), .overrun(c_ov), .rx_busy(c_busy)
    );

    // Record every accepted word {perr, ferr, data} and every overrun pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (a_ov) a_ovn++;
            if (b_ov) b_ovn++;
            if (c_ov) c_ovn++;
            if (a_valid && a_rdy) a_q.push_back({a_perr, a_ferr, a_data});
            if (b_valid && b_rdy) b_q.push_back({b_perr, b_ferr, 1'b0, b_data});
            if (c_valid && c_rdy) c_q.push_back({c_perr, c_ferr, c_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input int line, input logic v);
        case (line)
            0: a_rx = v;
            1: b_rx = v;
            default: c_rx = v;
        endcase
    endtask

    // Serial frame: start, nd data bits LSB first, optional parity bit, stop bits; optional one-cycle glitch mid-bit
    task automatic send_frame(input int line, input logic [7:0] w, input int nd, input bit has_par,
                              input logic pbit, input logic [1:0] stops, input int nstop, input int gbit);
        logic [15:0] fb;
        int nb;
        fb = '0;
        nb = 0;
        fb[nb] = 1'b0; nb++;
        for (int i = 0; i < nd; i++) begin
            fb[nb] = w[i]; nb++;
        end
        if (has_par) begin
            fb[nb] = pbit; nb++;
        end
        for (int i = 0; i < nstop; i++) begin
            fb[nb] = stops[i]; nb++;
        end
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < CD; j++) begin
                set_line(line, (i == gbit && j == 9) ? ~fb[i] : fb[i]);
                @(posedge clk);
                #1;
            end
        end
        set_line(line, 1'b1);
    endtask

    // What the receiver should deliver for a frame, from the framing rules alone
    function automatic logic [9:0] model(input logic [7:0] w, input int nd, input int pmode,
                                         input logic pbit, input logic [1:0] stops, input int nstop);
        logic [7:0] d;
        logic perr, ferr;
        d = w & 8'((1 << nd) - 1);
        perr = 1'b0;
        if (pmode == 1) perr = (((^d) ^ pbit) != 1'b0);
        if (pmode == 2) perr = (((^d) ^ pbit) != 1'b1);
        ferr = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        return {perr, ferr, d};
    endfunction

    task automatic cmp_q(input string tag, input logic [9:0] got[$], input int base, input logic [9:0] exp[$]);
        chk({tag, "_count"}, 32'(got.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got.size()) begin
                chk($sformatf("%s_word%0d", tag, i), 32'(got[base + i]), 32'(exp[i]));
            end
        end
    endtask

    initial begin
        logic [9:0] exp_q[$];
        logic [9:0] e;
        logic [7:0] w;
        logic       p;
        logic [1:0] st;
        int base, ov0;

        rst = 1'b1;
        a_rx = 1'b1; b_rx = 1'b1; c_rx = 1'b1;
        a_rdy = 1'b0; b_rdy = 1'b0; c_rdy = 1'b0;
        tick(4);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_perr", 32'(a_perr), 32'd0);
        chk("rst_ferr", 32'(a_ferr), 32'd0);
        chk("rst_overrun", 32'(a_ov), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_valid_b", 32'(b_valid), 32'd0);
        chk("rst_valid_c", 32'(c_valid), 32'd0);
        rst = 1'b0;
        tick(4);

        // 8N1 0xA5: busy from t0+4, rx_valid first seen at t0+157 (edges counted from t0 = first low sample)
        fork
            send_frame(0, 8'hA5, 8, 1'b0, 1'b0, 2'b11, 1, -1);
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("a5_busy_t0p3", 32'(a_busy), 32'd0);
                @(posedge clk);
                @(negedge clk);
                chk("a5_busy_t0p4", 32'(a_busy), 32'd1);
                repeat (152) @(posedge clk);
                @(negedge clk);
                chk("a5_valid_t0p156", 32'(a_valid), 32'd0);
                @(posedge clk);
                @(negedge clk);
                chk("a5_valid_t0p157", 32'(a_valid), 32'd1);
                chk("a5_data", 32'(a_data), 32'hA5);
                chk("a5_perr", 32'(a_perr), 32'd0);
                chk("a5_ferr", 32'(a_ferr), 32'd0);
                chk("a5_busy_done", 32'(a_busy), 32'd0);
            end
        join
        a_rdy = 1'b1;
        tick(1);
        a_rdy = 1'b0;
        chk("a5_accept_valid", 32'(a_valid), 32'd0);
        chk("a5_accept_hold", 32'(a_data), 32'hA5);

        // 7E1: correct then wrong parity for 0x35, followed by random words and parity bits
        b_rdy = 1'b1;
        base = b_q.size();
        exp_q.delete();
        send_frame(1, 8'h35, 7, 1'b1, 1'b0, 2'b11, 1, -1);
        exp_q.push_back(model(8'h35, 7, 1, 1'b0, 2'b11, 1));
        send_frame(1, 8'h35, 7, 1'b1, 1'b1, 2'b11, 1, -1);
        exp_q.push_back(model(8'h35, 7, 1, 1'b1, 2'b11, 1));
        tick(4);
        chk("e71_bad_hold_perr", 32'(b_perr), 32'd1);
        chk("e71_bad_hold_data", 32'(b_data), 32'h35);
        for (int i = 0; i < 12; i++) begin
            w = 8'($urandom_range(0, 127));
            p = 1'($urandom_range(0, 1));
            send_frame(1, w, 7, 1'b1, p, 2'b11, 1, -1);
            exp_q.push_back(model(w, 7, 1, p, 2'b11, 1));
            tick($urandom_range(0, 20));
        end
        tick(4);
        cmp_q("e71", b_q, base, exp_q);
        chk("e71_overrun", 32'(b_ovn), 32'd0);

        // 4-cycle low glitch is a false start
        a_rdy = 1'b1;
        base = a_q.size();
        ov0 = a_ovn;
        a_rx = 1'b0;
        tick(4);
        a_rx = 1'b1;
        tick(2);
        chk("glitch_busy", 32'(a_busy), 32'd1);
        tick(30);
        chk("glitch_busy_end", 32'(a_busy), 32'd0);
        chk("glitch_valid", 32'(a_valid), 32'd0);
        chk("glitch_words", 32'(a_q.size() - base), 32'd0);

        // One-cycle inverted pulse at mid-bit is voted out; random 8N1 words back-to-back with such pulses
        exp_q.delete();
        send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 2'b11, 1, 4);
        exp_q.push_back(model(8'h3C, 8, 0, 1'b0, 2'b11, 1));
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom_range(0, 255));
            send_frame(0, w, 8, 1'b0, 1'b0, 2'b11, 1, $urandom_range(1, 8));
            exp_q.push_back(model(w, 8, 0, 1'b0, 2'b11, 1));
        end
        tick(4);
        cmp_q("noise", a_q, base, exp_q);
        chk("noise_overrun", 32'(a_ovn - ov0), 32'd0);

        // 8N2 framing: bad second stop, bad first stop, then random stop corruption
        c_rdy = 1'b1;
        base = c_q.size();
        exp_q.delete();
        send_frame(2, 8'h96, 8, 1'b0, 1'b0, 2'b01, 2, -1);
        exp_q.push_back(model(8'h96, 8, 0, 1'b0, 2'b01, 2));
        tick(20);
        send_frame(2, 8'h69, 8, 1'b0, 1'b0, 2'b10, 2, -1);
        exp_q.push_back(model(8'h69, 8, 0, 1'b0, 2'b10, 2));
        tick(20);
        for (int i = 0; i < 8; i++) begin
            w = 8'($urandom_range(0, 255));
            st = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            send_frame(2, w, 8, 1'b0, 1'b0, st, 2, -1);
            exp_q.push_back(model(w, 8, 0, 1'b0, st, 2));
            tick($urandom_range(16, 40));
        end
        cmp_q("n82", c_q, base, exp_q);

        // Break: line low for three frame times gives exactly one 0x00 word with frame error
        base = c_q.size();
        exp_q.delete();
        exp_q.push_back(model(8'h00, 8, 0, 1'b0, 2'b00, 2));
        c_rx = 1'b0;
        tick(3 * 11 * CD);
        c_rx = 1'b1;
        tick(40);
        cmp_q("break", c_q, base, exp_q);
        chk("break_busy", 32'(c_busy), 32'd0);

        // Back-to-back with no consumer: first word held, the next two dropped with overrun pulses
        a_rdy = 1'b0;
        ov0 = a_ovn;
        send_frame(0, 8'h11, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        send_frame(0, 8'h22, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        send_frame(0, 8'h33, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        tick(4);
        chk("ovr_valid", 32'(a_valid), 32'd1);
        chk("ovr_data", 32'(a_data), 32'h11);
        chk("ovr_pulses", 32'(a_ovn - ov0), 32'd2);

        // Reset during data bit 4 while a word is held clears everything; no frame after release
        fork
            send_frame(0, 8'hF0, 8, 1'b0, 1'b0, 2'b11, 1, -1);
            begin
                tick(85);
                chk("rstmid_busy_before", 32'(a_busy), 32'd1);
                rst = 1'b1;
                #1;
                chk("rstmid_valid", 32'(a_valid), 32'd0);
                chk("rstmid_data", 32'(a_data), 32'd0);
                chk("rstmid_busy", 32'(a_busy), 32'd0);
                chk("rstmid_perr", 32'(a_perr), 32'd0);
                chk("rstmid_ferr", 32'(a_ferr), 32'd0);
                tick(3);
                rst = 1'b0;
            end
        join
        tick(40);
        chk("rstmid_after_valid", 32'(a_valid), 32'd0);
        chk("rstmid_after_busy", 32'(a_busy), 32'd0);

        // Clean 0x5A after reset, then three back-to-back words with ready tied high
        a_rdy = 1'b1;
        base = a_q.size();
        ov0 = a_ovn;
        exp_q.delete();
        send_frame(0, 8'h5A, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        exp_q.push_back(model(8'h5A, 8, 0, 1'b0, 2'b11, 1));
        tick(10);
        send_frame(0, 8'h11, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        send_frame(0, 8'h22, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        send_frame(0, 8'h33, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        exp_q.push_back(model(8'h11, 8, 0, 1'b0, 2'b11, 1));
        exp_q.push_back(model(8'h22, 8, 0, 1'b0, 2'b11, 1));
        exp_q.push_back(model(8'h33, 8, 0, 1'b0, 2'b11, 1));
        tick(4);
        cmp_q("tied", a_q, base, exp_q);
        chk("tied_overrun", 32'(a_ovn - ov0), 32'd0);
        e = exp_q[exp_q.size() - 1];
        chk("tied_hold_data", 32'(a_data), 32'(e[7:0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
